fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Fetch-stage producer of the opcode stream consumed by decode, i.e. the upstream end of the decode interface.
- Drives instruction memory and registers the IF/ID outputs: instruction word, immediate, return PC, valid and interrupt flag.
- Sequences reset-vector load, two-word LDM fetch, branch/return redirection and interrupt injection.
- An interrupt is injected as a synthetic CALL with o_interrupt=1.

Parameters:
PC_WIDTH, 32, program counter / instruction address width
INSTR_WIDTH, 16, instruction word width; opcode = word[15:11]
RESET_VECTOR_ADDR, 0, memory word holding the reset PC
INT_VECTOR_ADDR, 1, memory word holding the interrupt handler PC

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
o_imem_addr  out  PC_WIDTH  instruction memory address (combinational from state/PC)
i_imem_data  in  INSTR_WIDTH  instruction memory read data, valid in the same cycle
i_stall  in  1  hold all state and outputs (hazard stall)
i_redirect  in  1  branch taken, or RET/RTI PC pop resolved
i_redirect_pc  in  PC_WIDTH  new PC when i_redirect
i_int  in  1  external interrupt request, single-cycle pulse or level
o_instr  out  INSTR_WIDTH  registered instruction word to decode
o_imm  out  INSTR_WIDTH  registered immediate (LDM second word), else 0
o_pc  out  PC_WIDTH  registered return address (PC after this instruction)
o_valid  out  1  o_instr is a real instruction
o_interrupt  out  1  o_instr is an injected interrupt CALL

Behaviour:
- Opcode constants: NOP=00000, CALL=00101, LDM=10010. Unused alias 10001 is treated as LDM (two-word).
- Reset: state<=S_RESET_LOAD, pc<=0, int_pending<=0; o_instr=0, o_imm=0, o_pc=0, o_valid=0, o_interrupt=0.
- Outputs are registered: one-cycle latency from memory read to decode.
- States:
  - S_RESET_LOAD: addr=RESET_VECTOR_ADDR; pc<=data; emit NOP; ->S_RUN.
  - S_RUN: addr=pc.
    - If int_pending: emit {CALL,11'b0}, o_interrupt=1, o_pc=pc, o_valid=1; clear int_pending; pc unchanged; ->S_INT_LOAD.
    - Else if data opcode is LDM/10001: hold<=data; pc<=pc+1; emit NOP (o_valid=0); ->S_IMM.
    - Else: emit data, o_valid=1, o_pc=pc+1; pc<=pc+1.
  - S_IMM: addr=pc; emit hold, o_imm=data, o_valid=1, o_pc=pc+1; pc<=pc+1; ->S_RUN.
  - S_INT_LOAD: addr=INT_VECTOR_ADDR; pc<=data; emit NOP; ->S_RUN.
- Priority: i_reset > i_stall > i_redirect > interrupt injection > normal fetch.
- i_stall=1: pc, state, hold and all outputs frozen; int_pending may still be set.
- i_redirect=1 (not stalled):
  - pc<=i_redirect_pc; emit NOP (flush); ->S_RUN.
  - An LDM in progress (S_IMM) is discarded.
  - In S_RESET_LOAD or S_INT_LOAD, the redirect wins and the vector load is dropped.
- Interrupt handling:
  - i_int sets int_pending (sticky) until injected.
  - Injection only in S_RUN: never splits LDM from its immediate, never during a vector load.
  - i_int asserted while already pending has no further effect: one injection.
  - i_int in the same cycle as injection re-arms int_pending.
- Arithmetic and widths:
  - pc+1 wraps modulo 2^PC_WIDTH.
  - Vector data is zero-extended from INSTR_WIDTH to PC_WIDTH.
  - NOP emit means o_instr=0, o_imm=0, o_valid=0, o_interrupt=0; o_pc is held.
- Mid-operation reset: a synchronous reset in any state returns to S_RESET_LOAD next cycle and drops hold and int_pending.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams: OP_NOP, OP_CALL, OP_LDM, OP_LDM_ALT;
  - state encoding for S_RESET_LOAD, S_RUN, S_IMM, S_INT_LOAD;
  - the is_two_word(opcode) function.
- The decode stage reuses the same opcode constants.
- One sub-module, fetch_if_id_reg: the stall/flush-aware output register bank (instr, imm, pc, valid, interrupt).

Test Plan:
- Reset with M[0]=0x0010 -> NOP for 1 cycle, then o_instr=M[0x10], o_pc=0x11, o_valid=1.
- LDM: M[0x10]=0x9000 (LDM), M[0x11]=0xBEEF -> one NOP cycle, then o_instr=0x9000, o_imm=0xBEEF, o_pc=0x12.
- i_int pulse while in S_IMM -> LDM completes first; next output o_instr=0x2800, o_interrupt=1, o_pc=0x12; then NOP; then fetch from M[1].
- i_redirect with target 0x40 while i_stall=0 -> next output NOP, following output M[0x40] with o_pc=0x41.
- i_stall held 3 cycles during S_RUN with i_int pulsed -> outputs unchanged for 3 cycles; after release, CALL injected exactly once.
- pc=0xFFFFFFFF normal instruction -> o_pc=0x00000000 and next fetch address is 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants, fetch state encoding and opcode helpers shared by fetch and decode
package cpu_pkg;

    localparam int OPCODE_WIDTH = 5;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP     = 5'b00000;
    localparam logic [OPCODE_WIDTH-1:0] OP_CALL    = 5'b00101;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDM     = 5'b10010;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDM_ALT = 5'b10001;

    typedef enum logic [1:0] {
        S_RESET_LOAD = 2'd0,
        S_RUN        = 2'd1,
        S_IMM        = 2'd2,
        S_INT_LOAD   = 2'd3
    } fetch_state_t;

    // The unused alias of LDM still carries an immediate word, so it must be fetched as two words.
    function automatic logic is_two_word(input logic [OPCODE_WIDTH-1:0] opcode);
        return (opcode == OP_LDM) || (opcode == OP_LDM_ALT);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory, control and IF/ID signals of the fetch stage
interface fetch_sequencer_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 16
);

    logic [PC_WIDTH-1:0]    o_imem_addr;
    logic [INSTR_WIDTH-1:0] i_imem_data;
    logic                   i_stall;
    logic                   i_redirect;
    logic [PC_WIDTH-1:0]    i_redirect_pc;
    logic                   i_int;
    logic [INSTR_WIDTH-1:0] o_instr;
    logic [INSTR_WIDTH-1:0] o_imm;
    logic [PC_WIDTH-1:0]    o_pc;
    logic                   o_valid;
    logic                   o_interrupt;

    modport master (
        output o_imem_addr,
        input  i_imem_data,
        input  i_stall,
        input  i_redirect,
        input  i_redirect_pc,
        input  i_int,
        output o_instr,
        output o_imm,
        output o_pc,
        output o_valid,
        output o_interrupt
    );

    modport slave (
        input  o_imem_addr,
        output i_imem_data,
        output i_stall,
        output i_redirect,
        output i_redirect_pc,
        output i_int,
        input  o_instr,
        input  o_imm,
        input  o_pc,
        input  o_valid,
        input  o_interrupt
    );

endinterface

// File: rtl/fetch_if_id_reg.sv
// rtl/fetch_if_id_reg.sv - IF/ID output register bank that freezes on stall and emits NOP bubbles
module fetch_if_id_reg #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [INSTR_WIDTH-1:0] next_instr,
    input  logic [INSTR_WIDTH-1:0] next_imm,
    input  logic [PC_WIDTH-1:0]    next_pc,
    input  logic                   next_valid,
    input  logic                   next_interrupt,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [INSTR_WIDTH-1:0] imm,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   valid,
    output logic                   interrupt
);

    // A bubble zeroes the word fields but keeps the last return address visible to decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr     <= '0;
            imm       <= '0;
            pc        <= '0;
            valid     <= 1'b0;
            interrupt <= 1'b0;
        end else if (!stall) begin
            valid <= next_valid;
            if (next_valid) begin
                instr     <= next_instr;
                imm       <= next_imm;
                pc        <= next_pc;
                interrupt <= next_interrupt;
            end else begin
                instr     <= '0;
                imm       <= '0;
                interrupt <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch stage: vector loads, two-word LDM, redirects and interrupt injection
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int          PC_WIDTH          = 32,
    parameter int          INSTR_WIDTH       = 16,
    parameter int unsigned RESET_VECTOR_ADDR = 0,
    parameter int unsigned INT_VECTOR_ADDR   = 1
) (
    input logic               i_clk,
    input logic               i_reset,
    fetch_sequencer_if.master bus
);

    localparam logic [PC_WIDTH-1:0]    RESET_ADDR = PC_WIDTH'(RESET_VECTOR_ADDR);
    localparam logic [PC_WIDTH-1:0]    INT_ADDR   = PC_WIDTH'(INT_VECTOR_ADDR);
    localparam logic [INSTR_WIDTH-1:0] CALL_WORD  = {OP_CALL, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};

    fetch_state_t state, state_next;

    logic [PC_WIDTH-1:0]     pc, pc_next, pc_inc, vector_pc;
    logic [INSTR_WIDTH-1:0]  hold, hold_next;
    logic                    int_pending, int_next;
    logic [OPCODE_WIDTH-1:0] opcode;

    logic [INSTR_WIDTH-1:0]  d_instr, d_imm;
    logic [PC_WIDTH-1:0]     d_pc;
    logic                    d_valid, d_interrupt;

    assign pc_inc    = pc + PC_WIDTH'(1);
    assign vector_pc = PC_WIDTH'(bus.i_imem_data);
    assign opcode    = bus.i_imem_data[INSTR_WIDTH-1 -: OPCODE_WIDTH];

    always_comb begin
        case (state)
            S_RESET_LOAD: bus.o_imem_addr = RESET_ADDR;
            S_INT_LOAD:   bus.o_imem_addr = INT_ADDR;
            default:      bus.o_imem_addr = pc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_RESET_LOAD;
            pc          <= '0;
            hold        <= '0;
            int_pending <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            hold        <= hold_next;
            int_pending <= int_next;
        end
    end

    // Stall leaves every next value at its current one; only a new interrupt request may land.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        hold_next   = hold;
        int_next    = int_pending | bus.i_int;
        d_instr     = '0;
        d_imm       = '0;
        d_pc        = pc_inc;
        d_valid     = 1'b0;
        d_interrupt = 1'b0;

        if (!bus.i_stall) begin
            if (bus.i_redirect) begin
                pc_next    = bus.i_redirect_pc;
                state_next = S_RUN;
            end else begin
                case (state)
                    S_RESET_LOAD, S_INT_LOAD: begin
                        pc_next    = vector_pc;
                        state_next = S_RUN;
                    end
                    S_IMM: begin
                        d_instr    = hold;
                        d_imm      = bus.i_imem_data;
                        d_valid    = 1'b1;
                        pc_next    = pc_inc;
                        state_next = S_RUN;
                    end
                    S_RUN: begin
                        if (int_pending) begin
                            // The return address is the not-yet-executed instruction at pc.
                            d_instr     = CALL_WORD;
                            d_pc        = pc;
                            d_valid     = 1'b1;
                            d_interrupt = 1'b1;
                            int_next    = bus.i_int;
                            state_next  = S_INT_LOAD;
                        end else if (is_two_word(opcode)) begin
                            hold_next  = bus.i_imem_data;
                            pc_next    = pc_inc;
                            state_next = S_IMM;
                        end else begin
                            d_instr = bus.i_imem_data;
                            d_valid = 1'b1;
                            pc_next = pc_inc;
                        end
                    end
                    default: state_next = S_RESET_LOAD;
                endcase
            end
        end
    end

    fetch_if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id_reg (
        .clk            (i_clk),
        .reset          (i_reset),
        .stall          (bus.i_stall),
        .next_instr     (d_instr),
        .next_imm       (d_imm),
        .next_pc        (d_pc),
        .next_valid     (d_valid),
        .next_interrupt (d_interrupt),
        .instr          (bus.o_instr),
        .imm            (bus.o_imm),
        .pc             (bus.o_pc),
        .valid          (bus.o_valid),
        .interrupt      (bus.o_interrupt)
    );

endmodule
